dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: captures a load/store, waits LATENCY cycles,
// then pulses READY with read data / error and commits byte-masked stores.
module dmem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 1024
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        READY,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic        STALL
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIM = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Array is deliberately left out of reset so contents survive it.
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          err_c;
  logic          done;
  logic          wr_en;

  assign idx   = addr_q[AW+1:2];
  assign err_c = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= ADDR_LIM) ||
                 (we_q && (be_q == 4'b0000));
  assign done  = (state_q == BUSY) && (cnt_q == 4'd0);
  assign wr_en = done && we_q && !err_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    rdata_d = 32'h0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          we_d    = WE;
          be_d    = BE;
          addr_d  = ADDR;
          wdata_d = WDATA;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = err_c;
          rdata_d = (!we_q && !err_c) ? mem[idx] : 32'h0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // A REQ still high here is the one completing; never re-captured.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // wr_en depends on state_q, so an async reset during BUSY drops the store.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign READY = ready_q;
  assign RDATA = rdata_q;
  assign ERR   = err_q;
  assign STALL = REQ & ~ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance share
// the request bus; expected responses go through a scoreboard queue.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req1, req2, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        ready1, ready2, err1, err2, stall1, stall2;
  logic [31:0] rdata1, rdata2;

  logic        sel;
  logic        rdy_m, err_m, stall_m;
  logic [31:0] rdata_m;

  typedef struct packed { logic [31:0] rd; logic e; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2), .DEPTH(1024)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .REQ(req2), .WE(we), .BE(be), .ADDR(addr),
    .WDATA(wdata), .READY(ready2), .RDATA(rdata2), .ERR(err2), .STALL(stall2));

  dmem_responder #(.LATENCY(1), .DEPTH(1024)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .REQ(req1), .WE(we), .BE(be), .ADDR(addr),
    .WDATA(wdata), .READY(ready1), .RDATA(rdata1), .ERR(err1), .STALL(stall1));

  assign rdy_m   = sel ? ready1 : ready2;
  assign err_m   = sel ? err1   : err2;
  assign stall_m = sel ? stall1 : stall2;
  assign rdata_m = sel ? rdata1 : rdata2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the selected instance, checked end to end.
  task automatic do_req(input string tag, input logic s, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_e);
    int   lat_exp, lat, nstall;
    logic got;
    exp_t ex;
    lat_exp = s ? 1 : 2;
    @(negedge clk);
    sel = s; we = w; be = b; addr = a; wdata = d;
    if (s) req1 = 1'b1; else req2 = 1'b1;
    sbq.push_back('{rd: exp_rd, e: exp_e});
    @(posedge clk);
    got = 1'b0; lat = 0; nstall = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rdy_m) begin got = 1'b1; lat = k; end
      else if (stall_m) nstall++;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sbq.pop_front());
    end else begin
      ex = sbq.pop_front();
      chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
      chk({tag, "_rdata"}, rdata_m, ex.rd);
      chk({tag, "_err"}, {31'd0, err_m}, {31'd0, ex.e});
      chk({tag, "_stall_cycles"}, 32'(nstall), 32'(lat_exp));
      chk({tag, "_stall_low_at_ready"}, {31'd0, stall_m}, 32'd0);
    end
    req1 = 1'b0; req2 = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_one_cycle"}, {31'd0, rdy_m}, 32'd0);
  endtask

  initial begin
    int   n;
    exp_t ex;
    sel = 1'b0; rst_n = 1'b0; req1 = 1'b1; req2 = 1'b1;
    we = 1'b0; be = 4'hF; addr = 32'h0; wdata = 32'h0;

    // Reset held with REQ high: outputs quiet, STALL follows REQ.
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, ready2}, 32'd0);
      chk("rst_rdata", rdata2, 32'h0);
      chk("rst_err", {31'd0, err2}, 32'd0);
      chk("rst_stall", {31'd0, stall2}, 32'd1);
    end
    req1 = 1'b0; req2 = 1'b0; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_capture2", {31'd0, ready2}, 32'd0);
      chk("post_rst_no_capture1", {31'd0, ready1}, 32'd0);
    end

    // Store then load
    do_req("st10", 0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    do_req("ld10", 0, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // Byte mask
    do_req("st20", 0, 1, 4'hF, 32'h20, 32'h11223344, 32'h0, 0);
    do_req("st20m", 0, 1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, 0);
    do_req("ld20", 0, 0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 0);

    // Errors
    do_req("ld13", 0, 0, 4'hF, 32'h13, 32'h0, 32'h0, 1);
    do_req("st0", 0, 1, 4'hF, 32'h0, 32'h600DF00D, 32'h0, 0);
    do_req("st_oob", 0, 1, 4'hF, 32'd4096, 32'h00000BAD, 32'h0, 1);
    do_req("ld0", 0, 0, 4'hF, 32'h0, 32'h0, 32'h600DF00D, 0);
    do_req("st_be0", 0, 1, 4'h0, 32'h10, 32'h12345678, 32'h0, 1);
    do_req("ld10b", 0, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // Reset during BUSY drops the pending store
    do_req("st40z", 0, 1, 4'hF, 32'h40, 32'h0, 32'h0, 0);
    @(negedge clk);
    sel = 1'b0; we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h5A5A5A5A; req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_stall", {31'd0, stall2}, 32'd1);
    rst_n = 1'b0; req2 = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready2}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ready", {31'd0, ready2}, 32'd0);
      chk("abort_rdata", rdata2, 32'h0);
      chk("abort_err", {31'd0, err2}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_after_rel", {31'd0, ready2}, 32'd0);
    do_req("ld40", 0, 0, 4'hF, 32'h40, 32'h0, 32'h0, 0);

    // Back-to-back on the LATENCY=1 instance
    do_req("b_st100", 1, 1, 4'hF, 32'h100, 32'h01020304, 32'h0, 0);
    do_req("b_st104", 1, 1, 4'hF, 32'h104, 32'hCAFEF00D, 32'h0, 0);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h100; req1 = 1'b1;
    sbq.push_back('{rd: 32'h01020304, e: 1'b0});
    sbq.push_back('{rd: 32'hCAFEF00D, e: 1'b0});
    @(posedge clk);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ready1) begin
        if (n == 0) chk("b2b_first_at", 32'(k), 32'd1);
        else        chk("b2b_second_at", 32'(k), 32'd4);
        if (sbq.size() > 0) begin
          ex = sbq.pop_front();
          chk("b2b_rdata", rdata1, ex.rd);
          chk("b2b_err", {31'd0, err1}, {31'd0, ex.e});
        end
        n++;
        if (n == 1) addr = 32'h104;
        if (n >= 2) req1 = 1'b0;
      end
    end
    req1 = 1'b0;
    chk("b2b_ready_count", 32'(n), 32'd2);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
